// File: rtl/pulse_sync_multi.sv
// Multi-channel pulse synchronizer: per-channel synchronizer and edge detector,
// saturating pending-event counters, and a round-robin single-slot event queue.
module pulse_sync_multi #(
    parameter int  NCH         = 4,
    parameter int  SYNC_STAGES = 2,
    parameter int  EDGE_MODE   = 0,
    parameter int  CNT_W       = 3,
    localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk_dst,
    input  logic            rstn,
    input  logic [NCH-1:0]  pulse_src,
    output logic [NCH-1:0]  pulse_dst,
    output logic            evt_valid,
    output logic [CH_W-1:0] evt_ch,
    input  logic            evt_ready,
    output logic [NCH-1:0]  overflow,
    input  logic            ovf_clr
);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t                 state_reg, state_next;
    logic [SYNC_STAGES:0]   arm_reg;
    logic                   armed;
    logic [NCH-1:0]         edge_det;
    logic [NCH-1:0]         pulse_reg;
    logic [CNT_W-1:0]       pending_reg  [NCH];
    logic [CNT_W-1:0]       pending_next [NCH];
    logic [NCH-1:0]         has_pend;
    logic [NCH-1:0]         ovf_set;
    logic [NCH-1:0]         ovf_reg, ovf_next;
    logic [CH_W-1:0]        evt_ch_reg;
    logic [CH_W-1:0]        start_reg;
    logic [CH_W-1:0]        winner;
    logic                   any_pend;
    logic                   load;

    // Edge detection is held off until the delay flop carries a real sample,
    // so leaving reset never manufactures an edge from the cleared flops.
    assign armed = arm_reg[SYNC_STAGES];

    always_ff @(posedge clk_dst or negedge rstn) begin
        if (!rstn) begin
            arm_reg <= '0;
        end else begin
            arm_reg <= {arm_reg[SYNC_STAGES-1:0], 1'b1};
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   dly_reg;
            logic                   rise;
            logic                   fall;
            logic                   inc;
            logic                   dec;
            logic                   sat;

            always_ff @(posedge clk_dst or negedge rstn) begin
                if (!rstn) begin
                    sync_reg <= '0;
                    dly_reg  <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], pulse_src[gi]};
                    dly_reg  <= sync_reg[SYNC_STAGES-1];
                end
            end

            assign rise = sync_reg[SYNC_STAGES-1] & ~dly_reg;
            assign fall = ~sync_reg[SYNC_STAGES-1] & dly_reg;
            assign edge_det[gi] = armed & ((EDGE_MODE == 0) ? rise :
                                           (EDGE_MODE == 1) ? fall : (rise | fall));

            // A simultaneous increment and slot-load decrement cancel out.
            assign inc = pulse_reg[gi];
            assign dec = load && (winner == CH_W'(gi));
            assign sat = (pending_reg[gi] == {CNT_W{1'b1}});
            assign pending_next[gi] = (inc && !dec && !sat) ? pending_reg[gi] + CNT_W'(1) :
                                      (dec && !inc)         ? pending_reg[gi] - CNT_W'(1) :
                                                              pending_reg[gi];
            assign ovf_set[gi]  = inc & ~dec & sat;
            assign has_pend[gi] = |pending_reg[gi];
        end
    endgenerate

    // New overflow wins over a same-cycle clear.
    assign ovf_next = (ovf_reg & ~{NCH{ovf_clr}}) | ovf_set;

    always_comb begin
        int idx;
        any_pend = 1'b0;
        winner   = '0;
        idx      = 0;
        for (int off = 0; off < NCH; off++) begin
            idx = (int'(start_reg) + off) % NCH;
            if (!any_pend && has_pend[idx]) begin
                any_pend = 1'b1;
                winner   = CH_W'(idx);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            S_EMPTY: begin
                if (any_pend) begin
                    load       = 1'b1;
                    state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (evt_ready) begin
                    if (any_pend) begin
                        load = 1'b1;
                    end else begin
                        state_next = S_EMPTY;
                    end
                end
            end
            default: state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk_dst or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= S_EMPTY;
            pulse_reg  <= '0;
            ovf_reg    <= '0;
            evt_ch_reg <= '0;
            start_reg  <= '0;
            for (int i = 0; i < NCH; i++) begin
                pending_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            pulse_reg <= edge_det;
            ovf_reg   <= ovf_next;
            for (int i = 0; i < NCH; i++) begin
                pending_reg[i] <= pending_next[i];
            end
            if (load) begin
                evt_ch_reg <= winner;
                start_reg  <= CH_W'((int'(winner) + 1) % NCH);
            end
        end
    end

    assign pulse_dst = pulse_reg;
    assign evt_valid = (state_reg == S_FULL);
    assign evt_ch    = evt_ch_reg;
    assign overflow  = ovf_reg;

endmodule

// File: tb/tb_pulse_sync_multi.sv
// Self-checking bench for pulse_sync_multi: one rising-edge and one both-edge
// instance sharing stimulus, directed tables/sequences plus a random scoreboard run.
module tb_pulse_sync_multi;

    localparam int HN = 4096;

    logic       clk_dst = 1'b0;
    logic       rstn    = 1'b0;
    logic [3:0] src     = '0;
    logic       ready   = 1'b0;
    logic       clr     = 1'b0;

    logic [3:0] pd   [2];
    logic       ev   [2];
    logic [1:0] ech  [2];
    logic [3:0] ovf  [2];

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    logic [3:0] hist [HN];

    pulse_sync_multi #(.NCH(4), .SYNC_STAGES(2), .EDGE_MODE(0), .CNT_W(3)) dut0 (
        .clk_dst(clk_dst), .rstn(rstn), .pulse_src(src), .pulse_dst(pd[0]),
        .evt_valid(ev[0]), .evt_ch(ech[0]), .evt_ready(ready),
        .overflow(ovf[0]), .ovf_clr(clr));

    pulse_sync_multi #(.NCH(4), .SYNC_STAGES(2), .EDGE_MODE(2), .CNT_W(3)) dut2 (
        .clk_dst(clk_dst), .rstn(rstn), .pulse_src(src), .pulse_dst(pd[1]),
        .evt_valid(ev[1]), .evt_ch(ech[1]), .evt_ready(ready),
        .overflow(ovf[1]), .ovf_clr(clr));

    always #5 clk_dst = ~clk_dst;

    typedef struct {
        logic [3:0] src;
        logic       ready;
        logic [3:0] exp_p0;
        logic [3:0] exp_p2;
        logic       exp_valid;
        logic       chk_ch;
        logic [1:0] exp_ch;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs are sampled at the edge, outputs read 1 unit later.
    task automatic step();
        @(posedge clk_dst);
        edge_cnt++;
        hist[edge_cnt % HN] = src;
        #1;
    endtask

    task automatic do_reset(input logic [3:0] s);
        rstn = 1'b0;
        src  = s;
        step();
        step();
        rstn = 1'b1;
        edge_cnt = 0;
        repeat (5) step();
    endtask

    // Expected pulse after edge t: transition between the samples taken at t-3 and t-2,
    // only once both samples were taken after reset release.
    function automatic logic [3:0] model_pulse(input int mode, input int t);
        logic [3:0] a, b;
        if (t < 4) return 4'b0000;
        a = hist[(t - 2) % HN];
        b = hist[(t - 3) % HN];
        return (mode == 0) ? (a & ~b) : (a ^ b);
    endfunction

    initial begin
        vec_t vecs [10];
        int   n, w, first_t, second_t, p0_cnt, ev2_cnt;
        logic [1:0] acc_seq [3];
        logic [1:0] arb_exp [3];
        int   exp_cnt [2][4];
        int   acc_cnt [2][4];
        logic pre_v [2];
        logic [1:0] pre_c [2];
        logic [3:0] ep;

        vecs[0] = '{4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[2] = '{4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b0, 1'b0, 2'd0};
        vecs[3] = '{4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[4] = '{4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1};
        vecs[5] = '{4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[6] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[7] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[8] = '{4'b0000, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, 2'd0};
        vecs[9] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        arb_exp[0] = 2'd0; arb_exp[1] = 2'd2; arb_exp[2] = 2'd3;

        // Reset state with random inputs toggling underneath.
        for (int i = 0; i < 4; i++) begin
            src = 4'($urandom);
            step();
            for (int d = 0; d < 2; d++) begin
                check("rst_pulse", pd[d], 0);
                check("rst_valid", ev[d], 0);
                check("rst_ch", ech[d], 0);
                check("rst_ovf", ovf[d], 0);
            end
        end

        // Single edge on channel 1, table driven.
        ready = 1'b1;
        do_reset(4'b0000);
        for (int i = 0; i < 10; i++) begin
            src   = vecs[i].src;
            ready = vecs[i].ready;
            step();
            check("single_p0", pd[0], vecs[i].exp_p0);
            check("single_p2", pd[1], vecs[i].exp_p2);
            check("single_valid", ev[0], vecs[i].exp_valid);
            if (vecs[i].chk_ch) check("single_ch", ech[0], vecs[i].exp_ch);
        end

        // Round-robin arbitration with back-pressure.
        ready = 1'b0;
        do_reset(4'b0000);
        src = 4'b1101;
        step();
        w = 0;
        while (!ev[0] && w < 10) begin step(); w++; end
        check("arb_valid", ev[0], 1);
        check("arb_first_ch", ech[0], 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("arb_hold_valid", ev[0], 1);
            check("arb_hold_ch", ech[0], 0);
        end
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            acc_seq[i] = ev[0] ? ech[0] : 2'bxx;
            step();
            check("arb_order", acc_seq[i], arb_exp[i]);
        end
        check("arb_empty", ev[0], 0);
        src = 4'b0000;
        repeat (3) step();

        // Overflow on channel 2.
        ready = 1'b0;
        do_reset(4'b0000);
        for (int i = 0; i < 8; i++) begin
            src = 4'b0100; step();
            src = 4'b0000; step();
        end
        repeat (4) step();
        check("ovf_not_yet", ovf[0], 4'b0000);
        check("ovf_slot_valid", ev[0], 1);
        check("ovf_slot_ch", ech[0], 2);
        src = 4'b0100; step();
        src = 4'b0000; step();
        repeat (4) step();
        check("ovf_set", ovf[0], 4'b0100);
        ready = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (ev[0]) begin
                n++;
                check("ovf_drain_ch", ech[0], 2);
            end
            step();
        end
        check("ovf_drain_count", n, 8);
        check("ovf_sticky", ovf[0], 4'b0100);
        clr = 1'b1; step(); clr = 1'b0;
        check("ovf_cleared", ovf[0], 4'b0000);

        // Both-edge mode: one 4-cycle high level gives two pulses and two events.
        ready = 1'b1;
        do_reset(4'b0000);
        first_t = -1; second_t = -1; p0_cnt = 0; ev2_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            src = (i < 4) ? 4'b0001 : 4'b0000;
            if (ev[1] && ech[1] == 2'd0) ev2_cnt++;
            step();
            if (pd[1][0]) begin
                if (first_t < 0) first_t = i;
                else if (second_t < 0) second_t = i;
            end
            if (pd[0][0]) p0_cnt++;
        end
        check("both_first", first_t, 2);
        check("both_spacing", second_t - first_t, 4);
        check("both_events", ev2_cnt, 2);
        check("rise_only_pulses", p0_cnt, 1);

        // Reset mid-operation discards pending events; release with static inputs is silent.
        ready = 1'b0;
        do_reset(4'b0000);
        for (int i = 0; i < 3; i++) begin
            src = 4'b1000; step();
            src = 4'b0000; step();
        end
        repeat (5) step();
        check("mid_valid_before", ev[0], 1);
        #2 rstn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("mid_async_valid", ev[d], 0);
            check("mid_async_ovf", ovf[d], 0);
        end
        src = 4'b1010;
        step(); step();
        rstn = 1'b1;
        edge_cnt = 0;
        ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                check("mid_post_pulse", pd[d], 0);
                check("mid_post_valid", ev[d], 0);
            end
        end

        // Random run against the reference model and event scoreboard.
        do_reset(4'b0000);
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) begin exp_cnt[d][c] = 0; acc_cnt[d][c] = 0; end
        for (int cyc = 0; cyc < 2030; cyc++) begin
            if (cyc < 2000) begin
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, 15) == 0) src[b] = ~src[b];
                ready = ($urandom_range(0, 3) != 0);
            end else begin
                ready = 1'b1;
            end
            for (int d = 0; d < 2; d++) begin
                pre_v[d] = ev[d];
                pre_c[d] = ech[d];
                if (ev[d] && ready) acc_cnt[d][ech[d]]++;
            end
            step();
            for (int d = 0; d < 2; d++) begin
                ep = model_pulse((d == 0) ? 0 : 2, edge_cnt);
                check("rand_pulse", pd[d], ep);
                for (int c = 0; c < 4; c++) if (ep[c]) exp_cnt[d][c]++;
                if (pre_v[d] && !ready) begin
                    check("rand_hold_valid", ev[d], 1);
                    check("rand_hold_ch", ech[d], pre_c[d]);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) check("rand_event_count", acc_cnt[d][c], exp_cnt[d][c]);
            check("rand_no_ovf", ovf[d], 0);
            check("rand_drained", ev[d], 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
